// File: rtl/pr_hrav_pkg.sv
// pr_hrav_pkg: shared state encoding and core count for the reconfiguration scheduler
package pr_hrav_pkg;
   localparam int NCORES = 2;
   typedef enum logic [2:0] {IDLE, DRAIN, LOAD, RST_POST, DONE} state_e;
endpackage

// File: rtl/pr_hrav_reconfig_scheduler_if.sv
// pr_hrav_reconfig_scheduler_if: request, ICAP and per-core control bundle of the scheduler
interface pr_hrav_reconfig_scheduler_if;
   import pr_hrav_pkg::*;
   logic [NCORES-1:0] reconf_req, core_idle, core_enb, core_reset, axis_lp, reconf_ack, reconf_err;
   logic icap_done, icap_error, icap_start, icap_sel, busy;
   modport master (
      output reconf_req, core_idle, icap_done, icap_error,
      input  icap_start, icap_sel, core_enb, core_reset, axis_lp, reconf_ack, reconf_err, busy
   );
   modport slave (
      input  reconf_req, core_idle, icap_done, icap_error,
      output icap_start, icap_sel, core_enb, core_reset, axis_lp, reconf_ack, reconf_err, busy
   );
endinterface

// File: rtl/pr_hrav_reconfig_scheduler.sv
// pr_hrav_reconfig_scheduler: serialises partial reconfiguration of two cores through one ICAP
// (drain -> load -> post-load reset -> re-enable), with round-robin arbitration.
module pr_hrav_reconfig_scheduler
   import pr_hrav_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 1024,
   parameter int RESET_CYCLES  = 16
) (
   input logic ACLK,
   input logic RESETN,
   pr_hrav_reconfig_scheduler_if.slave bus
);
   localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
   localparam logic [15:0] RST_LAST   = 16'(RESET_CYCLES - 1);

   state_e state_q, state_d;
   logic sel_q, sel_d, ptr_q, ptr_d, grant;
   logic icap_start_q, icap_start_d, icap_sel_q, icap_sel_d, busy_q, busy_d;
   logic [15:0] cnt_q, cnt_d;
   logic [NCORES-1:0] enb_q, enb_d, rst_q, rst_d, lp_q, lp_d, ack_q, ack_d, err_q, err_d;

   assign grant = bus.reconf_req[ptr_q] ? ptr_q : ~ptr_q;

   always_ff @(posedge ACLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   // icap_error wins over a same-cycle icap_done
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            state_d = |bus.reconf_req ? DRAIN : IDLE;
            sel_d   = |bus.reconf_req ? grant : sel_q;
         end
         DRAIN:    state_d = bus.core_idle[sel_q] ? LOAD : (cnt_q == DRAIN_LAST) ? IDLE : DRAIN;
         LOAD:     state_d = bus.icap_error ? IDLE : bus.icap_done ? RST_POST : LOAD;
         RST_POST: state_d = (cnt_q == RST_LAST) ? DONE : RST_POST;
         default:  state_d = IDLE;
      endcase
      cnt_d = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 16'd1);
   end

   // Outputs are computed from the transition so that they register in step with the state.
   // A failed load leaves the core's reset/disable/isolate bits set, which is the quarantine.
   always_comb begin
      enb_d        = enb_q;
      rst_d        = rst_q;
      lp_d         = lp_q;
      ack_d        = '0;
      err_d        = '0;
      ptr_d        = (state_q == DONE) ? ~sel_q : ptr_q;
      icap_start_d = 1'b0;
      icap_sel_d   = icap_sel_q;
      busy_d       = state_d != IDLE;
      if (state_q == IDLE && state_d == DRAIN) begin
         lp_d[sel_d]  = 1'b1;
         enb_d[sel_d] = 1'b0;
      end
      if (state_q == DRAIN && state_d == LOAD) begin
         rst_d[sel_q] = 1'b1;
         icap_start_d = 1'b1;
         icap_sel_d   = sel_q;
      end
      if (state_q == DRAIN && state_d == IDLE) begin
         lp_d[sel_q]  = 1'b0;
         enb_d[sel_q] = 1'b1;
         err_d[sel_q] = 1'b1;
      end
      if (state_q == LOAD && state_d == IDLE) err_d[sel_q] = 1'b1;
      if (state_q == RST_POST && state_d == DONE) begin
         rst_d[sel_q] = 1'b0;
         enb_d[sel_q] = 1'b1;
         lp_d[sel_q]  = 1'b0;
         ack_d[sel_q] = 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge RESETN) begin
      if (!RESETN) begin
         enb_q        <= '1;
         rst_q        <= '0;
         lp_q         <= '0;
         ack_q        <= '0;
         err_q        <= '0;
         ptr_q        <= 1'b0;
         icap_start_q <= 1'b0;
         icap_sel_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         enb_q        <= enb_d;
         rst_q        <= rst_d;
         lp_q         <= lp_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         ptr_q        <= ptr_d;
         icap_start_q <= icap_start_d;
         icap_sel_q   <= icap_sel_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.core_enb   = enb_q;
   assign bus.core_reset = rst_q;
   assign bus.axis_lp    = lp_q;
   assign bus.reconf_ack = ack_q;
   assign bus.reconf_err = err_q;
   assign bus.icap_start = icap_start_q;
   assign bus.icap_sel   = icap_sel_q;
   assign bus.busy       = busy_q;
endmodule
